// File: rtl/spraid_spi_channel_if.sv
// Command/response and SPI pad bundle for one SPI RAID channel.
// master: register block + pad side (drives commands, divider, abort, miso).
// slave:  the channel engine (drives ready, responses, busy and the SPI pins).
interface spraid_spi_channel_if #(
    parameter int DIV_W = 8
);
    logic [DIV_W-1:0] clk_div;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_data;
    logic             cmd_last;
    logic             abort;
    logic             rsp_valid;
    logic [7:0]       rsp_data;
    logic             busy;
    logic             spi_clk;
    logic             spi_cs;
    logic             spi_mosi;
    logic             spi_miso;

    modport master (
        output clk_div, cmd_valid, cmd_data, cmd_last, abort, spi_miso,
        input  cmd_ready, rsp_valid, rsp_data, busy, spi_clk, spi_cs, spi_mosi
    );

    modport slave (
        input  clk_div, cmd_valid, cmd_data, cmd_last, abort, spi_miso,
        output cmd_ready, rsp_valid, rsp_data, busy, spi_clk, spi_cs, spi_mosi
    );
endinterface

// File: rtl/spraid_spi_channel.sv
// SPI mode-0 master engine, MSB first, 8-bit frames, CS held across bytes until cmd_last.
// Ports: wb_clk_i/wb_rst_i (async active-high reset), bus = slave side of spraid_spi_channel_if.
// Latency: 16*(clk_div+1) cycles accept-to-rsp_valid; cmd_ready only in IDLE/HOLD and never with abort.
module spraid_spi_channel #(
    parameter int DIV_W = 8
) (
    input logic              wb_clk_i,
    input logic              wb_rst_i,
    spraid_spi_channel_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SCK_L, SCK_H, HOLD, TRAIL, GAP} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_q;      // half-period latched at accept
    logic [DIV_W-1:0] cnt;        // cycles remaining in current phase
    logic             last_q;
    logic [7:0]       sh;         // tx bits shift out the top, rx bits enter the bottom
    logic [2:0]       bit_cnt;
    logic             rsp_valid_q;
    logic [7:0]       rsp_data_q;
    logic             spi_clk_q;
    logic             spi_cs_q;
    logic             spi_mosi_q;
    logic             phase_end;
    logic             accept;
    logic             abortable;

    assign phase_end     = (cnt == '0);
    assign bus.cmd_ready = (state == IDLE || state == HOLD) && !bus.abort;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign abortable     = (state == SCK_L) || (state == SCK_H) ||
                           (state == HOLD)  || (state == TRAIL);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.spi_clk   = spi_clk_q;
    assign bus.spi_cs    = spi_cs_q;
    assign bus.spi_mosi  = spi_mosi_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            div_q       <= '0;
            cnt         <= '0;
            last_q      <= 1'b0;
            sh          <= 8'h00;
            bit_cnt     <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            spi_clk_q   <= 1'b0;
            spi_cs_q    <= 1'b1;
            spi_mosi_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (bus.abort && abortable) begin
                // Partial byte is dropped; GAP still gives the slave N cycles of CS high.
                state     <= GAP;
                cnt       <= div_q;
                spi_clk_q <= 1'b0;
                spi_cs_q  <= 1'b1;
                bit_cnt   <= 3'd0;
            end else if (accept) begin
                state      <= SCK_L;
                cnt        <= bus.clk_div;
                div_q      <= bus.clk_div;
                last_q     <= bus.cmd_last;
                sh         <= bus.cmd_data;
                spi_mosi_q <= bus.cmd_data[7];
                spi_cs_q   <= 1'b0;
                spi_clk_q  <= 1'b0;
                bit_cnt    <= 3'd0;
            end else begin
                case (state)
                    SCK_L: begin
                        if (phase_end) begin
                            state     <= SCK_H;
                            cnt       <= div_q;
                            spi_clk_q <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    SCK_H: begin
                        if (phase_end) begin
                            spi_clk_q <= 1'b0;
                            sh        <= {sh[6:0], bus.spi_miso};
                            bit_cnt   <= bit_cnt + 1'b1;
                            cnt       <= div_q;
                            if (bit_cnt == 3'd7) begin
                                // mosi keeps the final bit while CS is still low.
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= {sh[6:0], bus.spi_miso};
                                state       <= last_q ? TRAIL : HOLD;
                            end else begin
                                spi_mosi_q <= sh[6];
                                state      <= SCK_L;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    TRAIL: begin
                        if (phase_end) begin
                            state    <= GAP;
                            cnt      <= div_q;
                            spi_cs_q <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    GAP: begin
                        if (phase_end) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        // IDLE and HOLD only leave on accept or abort.
                    end
                endcase
            end
        end
    end
endmodule
